id_ex_stage: RTL

//  Decode->execute pipeline stage that feeds the 64-bit ALU. Accepts decoded operands, selects operand B
//  (register or immediate) and generates the 4-bit ALU control from ALUOp and the 11-bit opcode.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/id_ex_stage_if.sv | 38 +++
 rtl/alu_ctrl_dec.sv | 38 +++
 rtl/id_ex_stage.sv | 114 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ALU control codes, ALUOp and R-type opcode encodings, and the ID/EX entry type
// shared by the decode->execute stage and the single-cycle datapath.
package cpu_pkg;

  localparam int EX_DW = 64;
  localparam int EX_RW = 5;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ORR = 4'b0001;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_LDST  = 2'b00,
    ALUOP_CBZ   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ILL   = 2'b11
  } alu_op_e;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  typedef struct packed {
    logic [EX_DW-1:0] data1;
    logic [EX_DW-1:0] data2;
    logic [3:0]       control;
    logic [EX_RW-1:0] rd;
    logic             err;
  } ex_entry_t;

  // Idle register contents: zero data with an ADD control so the ALU sees a harmless op.
  localparam ex_entry_t RESET_ENTRY = '{data1: '0, data2: '0, control: ALU_ADD, rd: '0, err: 1'b0};

endpackage

// File: rtl/id_ex_stage_if.sv
// Upstream/downstream handshake bundle of the ID/EX stage; the stage uses the
// slave view, the decode-side driver and ALU-side consumer together use master.
interface id_ex_stage_if
  import cpu_pkg::*;
#(
  parameter int DW = EX_DW,
  parameter int RW = EX_RW
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data1;
  logic [DW-1:0] in_data2;
  logic [DW-1:0] in_imm;
  logic          in_alu_src;
  logic [1:0]    in_alu_op;
  logic [10:0]   in_opcode;
  logic [RW-1:0] in_rd;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data1;
  logic [DW-1:0] out_data2;
  logic [3:0]    out_control;
  logic [RW-1:0] out_rd;
  logic          out_err;

  modport master (
    output in_valid, in_data1, in_data2, in_imm, in_alu_src, in_alu_op, in_opcode, in_rd,
    output flush, out_ready,
    input  in_ready, out_valid, out_data1, out_data2, out_control, out_rd, out_err
  );

  modport slave (
    input  in_valid, in_data1, in_data2, in_imm, in_alu_src, in_alu_op, in_opcode, in_rd,
    input  flush, out_ready,
    output in_ready, out_valid, out_data1, out_data2, out_control, out_rd, out_err
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: ALUOp plus instruction[31:21] to 4-bit
// ALU control, flagging unsupported combinations with err.
module alu_ctrl_dec
  import cpu_pkg::*;
(
  input  logic [1:0]  alu_op_i,
  input  logic [10:0] opcode_i,
  output logic [3:0]  control_o,
  output logic        err_o
);

  always_comb begin
    control_o = ALU_ILL;
    err_o     = 1'b1;
    case (alu_op_i)
      ALUOP_LDST: begin
        control_o = ALU_ADD;
        err_o     = 1'b0;
      end
      ALUOP_CBZ: begin
        control_o = ALU_SUB;
        err_o     = 1'b0;
      end
      ALUOP_RTYPE: begin
        err_o = 1'b0;
        case (opcode_i)
          OPC_ADD: control_o = ALU_ADD;
          OPC_SUB: control_o = ALU_SUB;
          OPC_AND: control_o = ALU_AND;
          OPC_ORR: control_o = ALU_ORR;
          default: err_o = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute stage: operand-B mux, ALU control decode and a 2-entry skid buffer
// with registered in_ready. Optional macro STALL_CNT_EN adds a saturating stall counter.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DW = EX_DW,
  parameter int RW = EX_RW
`ifdef STALL_CNT_EN
  , parameter int CNTW = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  id_ex_stage_if.slave     bus
`ifdef STALL_CNT_EN
  , output logic [CNTW-1:0] stall_cnt
`endif
);

  logic [DW-1:0] opB;
  logic [RW-1:0] rdIn;
  logic [3:0]    decControl;
  logic          decErr;
  ex_entry_t     inEntry;
  logic          accept;
  logic          emit;

  ex_entry_t mainEntry_q, mainEntry_d;
  ex_entry_t skidEntry_q, skidEntry_d;
  logic      mainValid_q, mainValid_d;
  logic      skidValid_q, skidValid_d;
  logic      inReady_q;

  alu_ctrl_dec u_dec (
    .alu_op_i  (bus.in_alu_op),
    .opcode_i  (bus.in_opcode),
    .control_o (decControl),
    .err_o     (decErr)
  );

  assign opB     = bus.in_alu_src ? bus.in_imm : bus.in_data2;
  assign rdIn    = bus.in_rd;
  assign inEntry = '{data1: bus.in_data1, data2: opB, control: decControl, rd: rdIn, err: decErr};
  assign accept  = bus.in_valid & inReady_q;
  assign emit    = mainValid_q & bus.out_ready;

  // Skid entry always has priority into main so ordering stays FIFO.
  always_comb begin
    mainEntry_d = mainEntry_q;
    mainValid_d = mainValid_q;
    skidEntry_d = skidEntry_q;
    skidValid_d = skidValid_q;
    if (bus.flush) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (!mainValid_q || emit) begin
      if (skidValid_q) begin
        mainEntry_d = skidEntry_q;
        mainValid_d = 1'b1;
        skidValid_d = accept;
        if (accept) skidEntry_d = inEntry;
      end else begin
        mainValid_d = accept;
        if (accept) mainEntry_d = inEntry;
      end
    end else if (accept) begin
      skidEntry_d = inEntry;
      skidValid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mainEntry_q <= RESET_ENTRY;
      skidEntry_q <= RESET_ENTRY;
      mainValid_q <= 1'b0;
      skidValid_q <= 1'b0;
      inReady_q   <= 1'b0;
    end else begin
      mainEntry_q <= mainEntry_d;
      skidEntry_q <= skidEntry_d;
      mainValid_q <= mainValid_d;
      skidValid_q <= skidValid_d;
      inReady_q   <= !skidValid_d;
    end
  end

  assign bus.in_ready    = inReady_q;
  assign bus.out_valid   = mainValid_q;
  assign bus.out_data1   = mainEntry_q.data1;
  assign bus.out_data2   = mainEntry_q.data2;
  assign bus.out_control = mainEntry_q.control;
  assign bus.out_rd      = mainEntry_q.rd;
  assign bus.out_err     = mainEntry_q.err;

`ifdef STALL_CNT_EN
  logic [CNTW-1:0] stallCnt_q, stallCnt_d;

  // Counts cycles the ALU side holds back a valid entry; sticks at all-ones.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (mainValid_q && !bus.out_ready && (stallCnt_q != '1))
      stallCnt_d = stallCnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stallCnt_q <= '0;
    else       stallCnt_q <= stallCnt_d;
  end

  assign stall_cnt = stallCnt_q;
`endif

endmodule
